// File: rtl/nv_lsd_norm_pipe.sv
// nv_lsd_norm_pipe
// Two-stage, back-pressurable leading-sign / leading-zero detector with a
// left normaliser. It sits in front of the int-to-float converters and the
// CDP/SDP normalisation paths. Each transaction carries its own mode bit, so
// operations in different modes may follow each other back to back.
//
// Ports:
//   nvdla_core_clk  clock; all state updates on the rising edge
//   nvdla_core_rst  asynchronous, active-high reset
//   in_pvld/in_prdy input handshake; a transfer happens when both are high
//   in_a            operand
//   in_mode         0 = leading-sign detect, 1 = leading-zero detect
//   out_pvld/out_prdy output handshake; a transfer happens when both are high
//   out_enc         redundant-sign-bit count (LSD) or leading-zero count (LZD)
//   out_dec         one-hot marker at the last sign bit / leading one
//   out_norm        in_a shifted left by out_enc, zero-filled
//   out_flag        operand is all-equal (LSD) or zero (LZD)
//
// Stage 1 registers the operand, its mode, and the count and flag.
// Stage 2 builds the marker and the shifted operand from the stage 1
// registers. No path runs from in_* to out_*. in_prdy depends
// combinationally on out_prdy.

module nv_lsd_norm_pipe #(
    parameter  int A_WIDTH   = 32,
    localparam int ENC_WIDTH = $clog2(A_WIDTH + 1)
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 in_pvld,
    output logic                 in_prdy,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic                 in_mode,
    output logic                 out_pvld,
    input  logic                 out_prdy,
    output logic [ENC_WIDTH-1:0] out_enc,
    output logic [A_WIDTH-1:0]   out_dec,
    output logic [A_WIDTH-1:0]   out_norm,
    output logic                 out_flag
);

    // The marker is this value shifted right by the count. A zero operand
    // in LZD mode has a count of A_WIDTH, which shifts the bit out entirely.
    localparam logic [A_WIDTH-1:0] MSB_ONE = {1'b1, {(A_WIDTH-1){1'b0}}};

    logic                 s1_vld_q,  s1_vld_d;
    logic [A_WIDTH-1:0]   s1_a_q,    s1_a_d;
    logic                 s1_mode_q, s1_mode_d;
    logic [ENC_WIDTH-1:0] s1_enc_q,  s1_enc_d;
    logic                 s1_flag_q, s1_flag_d;

    logic                 s2_vld_q,  s2_vld_d;
    logic [ENC_WIDTH-1:0] s2_enc_q,  s2_enc_d;
    logic [A_WIDTH-1:0]   s2_dec_q,  s2_dec_d;
    logic [A_WIDTH-1:0]   s2_norm_q, s2_norm_d;
    logic                 s2_flag_q, s2_flag_d;

    logic                 s1_rdy, s2_rdy, s1_load, s2_load;
    logic [ENC_WIDTH-1:0] lsd_enc, lzd_enc;
    logic                 lsd_found, lzd_found;

    // Scan from the MSB side for the first bit that breaks the run. For
    // LSD, the run is the sign bit and its copies. For LZD, the run is the
    // leading zeros. If nothing breaks the run, the count keeps its default:
    // A_WIDTH-1 for LSD and A_WIDTH for LZD.
    always_comb begin
        lsd_enc   = ENC_WIDTH'(A_WIDTH - 1);
        lzd_enc   = ENC_WIDTH'(A_WIDTH);
        lsd_found = 1'b0;
        lzd_found = 1'b0;
        for (int i = A_WIDTH - 2; i >= 0; i--) begin
            if (!lsd_found && (in_a[i] != in_a[A_WIDTH-1])) begin
                lsd_enc   = ENC_WIDTH'(A_WIDTH - 2 - i);
                lsd_found = 1'b1;
            end
        end
        for (int i = A_WIDTH - 1; i >= 0; i--) begin
            if (!lzd_found && in_a[i]) begin
                lzd_enc   = ENC_WIDTH'(A_WIDTH - 1 - i);
                lzd_found = 1'b1;
            end
        end
    end

    // Ready chaining runs backwards from the output. A stage can accept
    // when it is empty, or when it is handing its contents on in the same
    // cycle. This lets a full pipe push and pop together without a bubble.
    always_comb begin
        s2_rdy  = !s2_vld_q || out_prdy;
        s1_rdy  = !s1_vld_q || s2_rdy;
        in_prdy = s1_rdy;
        s1_load = in_pvld && s1_rdy;
        s2_load = s1_vld_q && s2_rdy;
    end

    // Stage 1 next state. Data registers change only on an accept, so held
    // contents stay stable while the pipe is stalled.
    always_comb begin
        s1_vld_d  = s1_rdy ? in_pvld : s1_vld_q;
        s1_a_d    = s1_a_q;
        s1_mode_d = s1_mode_q;
        s1_enc_d  = s1_enc_q;
        s1_flag_d = s1_flag_q;
        if (s1_load) begin
            s1_a_d    = in_a;
            s1_mode_d = in_mode;
            s1_enc_d  = in_mode ? lzd_enc : lsd_enc;
            s1_flag_d = in_mode ? !lzd_found : !lsd_found;
        end
    end

    // Stage 2 next state: marker and barrel shift, both driven by the
    // stored count. A shift by A_WIDTH or more yields zero.
    always_comb begin
        s2_vld_d  = s2_rdy ? s1_vld_q : s2_vld_q;
        s2_enc_d  = s2_enc_q;
        s2_dec_d  = s2_dec_q;
        s2_norm_d = s2_norm_q;
        s2_flag_d = s2_flag_q;
        if (s2_load) begin
            s2_enc_d  = s1_enc_q;
            s2_dec_d  = (s1_mode_q && s1_flag_q) ? '0 : (MSB_ONE >> s1_enc_q);
            s2_norm_d = s1_a_q << s1_enc_q;
            s2_flag_d = s1_flag_q;
        end
    end

    // All pipeline state. Reset clears valids and outputs at once, which
    // drops any transactions still in flight.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_mode_q <= 1'b0;
            s1_enc_q  <= '0;
            s1_flag_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_enc_q  <= '0;
            s2_dec_q  <= '0;
            s2_norm_q <= '0;
            s2_flag_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_mode_q <= s1_mode_d;
            s1_enc_q  <= s1_enc_d;
            s1_flag_q <= s1_flag_d;
            s2_vld_q  <= s2_vld_d;
            s2_enc_q  <= s2_enc_d;
            s2_dec_q  <= s2_dec_d;
            s2_norm_q <= s2_norm_d;
            s2_flag_q <= s2_flag_d;
        end
    end

    assign out_pvld = s2_vld_q;
    assign out_enc  = s2_enc_q;
    assign out_dec  = s2_dec_q;
    assign out_norm = s2_norm_q;
    assign out_flag = s2_flag_q;

endmodule

// File: tb/tb_nv_lsd_norm_pipe.sv
// tb_nv_lsd_norm_pipe
// Directed bench for nv_lsd_norm_pipe with A_WIDTH = 8.
// Inputs change just after the falling edge. Outputs and in_prdy are
// sampled 1 time unit later, which is well away from the rising edge.

module tb_nv_lsd_norm_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inPvld = 1'b0;
    logic         inPrdy;
    logic [W-1:0] inA = '0;
    logic         inMode = 1'b0;
    logic         outPvld;
    logic         outPrdy = 1'b1;
    logic [3:0]   outEnc;
    logic [W-1:0] outDec;
    logic [W-1:0] outNorm;
    logic         outFlag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   enc;
        logic [W-1:0] dec;
        logic [W-1:0] norm;
        logic         flag;
        int           acc;
    } expT;

    expT expQ[$];

    logic [W-1:0] vecs [16] = '{8'h16, 8'hE8, 8'hFF, 8'h00, 8'h01, 8'hA0, 8'h80, 8'h7F,
                               8'h40, 8'hC0, 8'h3C, 8'hFE, 8'h02, 8'h55, 8'h0F, 8'hF1};

    nv_lsd_norm_pipe #(.A_WIDTH(W)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_pvld        (inPvld),
        .in_prdy        (inPrdy),
        .in_a           (inA),
        .in_mode        (inMode),
        .out_pvld       (outPvld),
        .out_prdy       (outPrdy),
        .out_enc        (outEnc),
        .out_dec        (outDec),
        .out_norm       (outNorm),
        .out_flag       (outFlag)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Guards against a hung pipe.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model. It counts the run bit by bit from the MSB, then
    // builds the marker and the shifted value one bit at a time.
    function automatic expT refModel(input logic [W-1:0] a, input logic m);
        expT e;
        int n;
        logic [W-1:0] s;
        if (m) begin
            n = 0;
            while (n < W && a[W-1-n] == 1'b0) n++;
        end else begin
            n = 1;
            while (n < W && a[W-1-n] == a[W-1]) n++;
            n = n - 1;
        end
        e.enc = 4'(n);
        e.dec = '0;
        if (n < W && !(m && a == '0)) e.dec[W-1-n] = 1'b1;
        s = a;
        for (int k = 0; k < n; k++) s = {s[W-2:0], 1'b0};
        e.norm = s;
        e.flag = m ? (a == '0) : (n == W-1);
        e.acc  = 0;
        return e;
    endfunction

    // Makes one comparison and counts it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one transaction into an idle pipe and follows it through.
    // It is accepted at edge N, is valid on the output between edges N+1
    // and N+2, is consumed at edge N+2, and leaves the pipe empty afterwards.
    task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic m,
                                 input logic [3:0] eEnc, input logic [W-1:0] eDec,
                                 input logic [W-1:0] eNorm, input logic eFlag);
        @(negedge clk);
        inPvld = 1'b1; inA = a; inMode = m; outPrdy = 1'b1;
        #1 checkOutput({tag, " in_prdy"}, 32'(inPrdy), 32'd1);
        @(negedge clk);
        inPvld = 1'b0;
        #1 checkOutput({tag, " pvld_n1"}, 32'(outPvld), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, " pvld"}, 32'(outPvld), 32'd1);
        checkOutput({tag, " enc"},  32'(outEnc),  32'(eEnc));
        checkOutput({tag, " dec"},  32'(outDec),  32'(eDec));
        checkOutput({tag, " norm"}, 32'(outNorm), 32'(eNorm));
        checkOutput({tag, " flag"}, 32'(outFlag), 32'(eFlag));
        @(negedge clk);
        #1 checkOutput({tag, " pvld_after"}, 32'(outPvld), 32'd0);
    endtask

    // Streams nTx vectors with alternating modes. out_prdy is held low
    // for the first stallCycles cycles. Results come back through the
    // scoreboard. The bench also checks ready, output stability while
    // stalled and, optionally, the two-cycle latency.
    task automatic runStream(input string tag, input int nTx, input int stallCycles, input bit checkLat);
        int   sent = 0;
        int   cyc = 0;
        bit   holdPrev = 1'b0;
        logic [3:0]   pEnc = '0;
        logic [W-1:0] pDec = '0;
        logic [W-1:0] pNorm = '0;
        logic         pFlag = 1'b0;
        expT  e;
        while ((sent < nTx || expQ.size() > 0) && cyc < 200) begin
            @(negedge clk);
            outPrdy = (cyc >= stallCycles);
            inPvld  = (sent < nTx);
            if (sent < nTx) begin
                inA    = vecs[sent % 16];
                inMode = sent[0];
            end
            #1;
            if (holdPrev) begin
                checkOutput({tag, " hold_enc"},  32'(outEnc),  32'(pEnc));
                checkOutput({tag, " hold_dec"},  32'(outDec),  32'(pDec));
                checkOutput({tag, " hold_norm"}, 32'(outNorm), 32'(pNorm));
                checkOutput({tag, " hold_flag"}, 32'(outFlag), 32'(pFlag));
                checkOutput({tag, " hold_pvld"}, 32'(outPvld), 32'd1);
            end
            checkOutput({tag, " in_prdy"}, 32'(inPrdy), 32'(outPrdy || expQ.size() < 2));
            if (outPvld && outPrdy) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, " spurious"}, 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({tag, " enc"},  32'(outEnc),  32'(e.enc));
                    checkOutput({tag, " dec"},  32'(outDec),  32'(e.dec));
                    checkOutput({tag, " norm"}, 32'(outNorm), 32'(e.norm));
                    checkOutput({tag, " flag"}, 32'(outFlag), 32'(e.flag));
                    if (checkLat) checkOutput({tag, " latency"}, 32'(cyc - e.acc), 32'd2);
                end
            end
            if (inPvld && inPrdy) begin
                e = refModel(inA, inMode);
                e.acc = cyc;
                expQ.push_back(e);
                sent++;
            end
            holdPrev = outPvld && !outPrdy;
            pEnc = outEnc; pDec = outDec; pNorm = outNorm; pFlag = outFlag;
            cyc++;
        end
        checkOutput({tag, " sent"},  32'(sent), 32'(nTx));
        checkOutput({tag, " drain"}, 32'(expQ.size()), 32'd0);
        @(negedge clk);
        inPvld = 1'b0; outPrdy = 1'b1;
        #1 checkOutput({tag, " idle"}, 32'(outPvld), 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        // Power-up reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst pvld", 32'(outPvld), 32'd0);
        checkOutput("rst enc",  32'(outEnc),  32'd0);
        checkOutput("rst dec",  32'(outDec),  32'd0);
        checkOutput("rst norm", 32'(outNorm), 32'd0);
        checkOutput("rst flag", 32'(outFlag), 32'd0);
        checkOutput("rst prdy", 32'(inPrdy),  32'd1);

        // Directed vectors, one at a time
        applyStimulus("lsd16",  8'h16, 1'b0, 4'd2, 8'h20, 8'h58, 1'b0);
        applyStimulus("lsdE8",  8'hE8, 1'b0, 4'd2, 8'h20, 8'hA0, 1'b0);
        applyStimulus("lsdFF",  8'hFF, 1'b0, 4'd7, 8'h01, 8'h80, 1'b1);
        applyStimulus("lsd00",  8'h00, 1'b0, 4'd7, 8'h01, 8'h00, 1'b1);
        applyStimulus("lzd00",  8'h00, 1'b1, 4'd8, 8'h00, 8'h00, 1'b1);
        applyStimulus("lzd01",  8'h01, 1'b1, 4'd7, 8'h01, 8'h80, 1'b0);
        applyStimulus("lzdA0",  8'hA0, 1'b1, 4'd0, 8'h80, 8'hA0, 1'b0);

        // Back-to-back stream with modes alternating
        runStream("stream", 16, 0, 1'b1);

        // Backpressure: 4 stalled cycles, then drain
        runStream("bp", 5, 4, 1'b0);

        // Reset with two transactions in flight
        @(negedge clk);
        outPrdy = 1'b0; inPvld = 1'b1; inA = 8'h16; inMode = 1'b0;
        @(negedge clk);
        inA = 8'h01; inMode = 1'b1;
        @(negedge clk);
        inPvld = 1'b0;
        #1;
        checkOutput("pre_rst pvld", 32'(outPvld), 32'd1);
        checkOutput("pre_rst enc",  32'(outEnc),  32'd2);
        checkOutput("pre_rst prdy", 32'(inPrdy),  32'd0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst pvld", 32'(outPvld), 32'd0);
        checkOutput("mid_rst enc",  32'(outEnc),  32'd0);
        checkOutput("mid_rst dec",  32'(outDec),  32'd0);
        checkOutput("mid_rst norm", 32'(outNorm), 32'd0);
        checkOutput("mid_rst flag", 32'(outFlag), 32'd0);
        checkOutput("mid_rst prdy", 32'(inPrdy),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        outPrdy = 1'b1;
        applyStimulus("post_rst", 8'h3C, 1'b0, 4'd1, 8'h40, 8'h78, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
